fft16_r4_sched: RTL and testbench

Sequencer for the 16-point radix-4 decimation-in-frequency (DIF) FFT built around the shared combinational radix-4 butterfly (16-bit signed complex, 4 in / 4 out).
- Buffers a 16-sample frame and time-shares the single butterfly over 2 stages × 4 groups.
- Applies inter-stage twiddles with one internal complex multiplier.
- Streams the 16 results out in natural order.

---
 rtl/fft16_r4_sched.sv | 211 +++++++++++++++++++++
 tb/tb_fft16_r4_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_r4_sched.sv
// fft16_r4_sched: 16-point radix-4 DIF FFT sequencer that time-shares one external butterfly.
// Build macro FFT_SCALE_EN: arithmetic shift right by 2 of every captured butterfly lane.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting 16 input samples into the buffer
// ISSUE  | presenting one group of four to the butterfly
// WAIT   | counting down butterfly pipeline latency
// TWID   | stage-0 twiddle multiply, one lane per cycle
// WRITE  | in-place writeback of the four lanes
// UNLOAD | streaming results in natural bin order
module fft16_r4_sched #(
  parameter int DW     = 16,
  parameter int BF_LAT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_re,
  input  logic [DW-1:0]   in_im,
  output logic [8*DW-1:0] bf_in,
  input  logic [8*DW-1:0] bf_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_re,
  output logic [DW-1:0]   out_im,
  output logic [3:0]      out_idx,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_TWID, S_WRITE, S_UNLOAD
  } state_t;

  localparam int WW   = (BF_LAT > 1) ? $clog2(BF_LAT + 1) : 1;
  localparam int SMAX = (1 << (DW - 1)) - 1;
  localparam int SMIN = -(1 << (DW - 1));

  state_t state, state_nxt;
  logic [DW-1:0] mem_re [16];
  logic [DW-1:0] mem_im [16];
  logic signed [DW-1:0] lane_re [4];
  logic signed [DW-1:0] lane_im [4];
  logic [3:0]    cnt;
  logic          stage;
  logic [1:0]    g;
  logic [1:0]    tq;
  logic [WW-1:0] wcnt;
  logic          done_r;
  logic          cap_en;
  logic [3:0]    uaddr;

  logic [3:0]           m;
  logic signed [15:0]   tw_c, tw_s;
  logic signed [DW-1:0] ma, mb;
  logic signed [31:0]   pr, pi;
  logic [DW-1:0]        tw_re, tw_im;

  // Stage 0 reads stride-4 groups, stage 1 reads contiguous groups.
  function automatic logic [3:0] lane_addr(input logic st, input logic [1:0] grp,
                                           input logic [1:0] q);
    return st ? {grp, q} : {q, grp};
  endfunction

  function automatic logic [DW-1:0] sat(input logic signed [31:0] v);
    if (v > SMAX) return SMAX[DW-1:0];
    if (v < SMIN) return SMIN[DW-1:0];
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] v);
`ifdef FFT_SCALE_EN
    return $signed(v) >>> 2;
`else
    return v;
`endif
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD:   if (in_valid && cnt == 4'd15) state_nxt = S_ISSUE;
      S_ISSUE:  if (BF_LAT > 0) state_nxt = S_WAIT;
                else state_nxt = stage ? S_WRITE : S_TWID;
      S_WAIT:   if (wcnt == '0) state_nxt = stage ? S_WRITE : S_TWID;
      S_TWID:   if (tq == 2'd3) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = (stage && g == 2'd3) ? S_UNLOAD : S_ISSUE;
      S_UNLOAD: if (out_ready && cnt == 4'd15) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign cap_en = (BF_LAT == 0) ? (state == S_ISSUE) : (state == S_WAIT && wcnt == '0);

  always_comb begin
    bf_in = '0;
    if (state == S_ISSUE || state == S_WAIT) begin
      for (int q = 0; q < 4; q++) begin
        bf_in[(7-2*q)*DW +: DW] = mem_re[lane_addr(stage, g, q[1:0])];
        bf_in[(6-2*q)*DW +: DW] = mem_im[lane_addr(stage, g, q[1:0])];
      end
    end
  end

  // Twiddle W16^m in Q1.14, m = g*q never exceeds 9.
  always_comb begin
    m = {2'b00, g} * {2'b00, tq};
    case (m)
      4'd0:    begin tw_c =  16'sd16384; tw_s =  16'sd0;     end
      4'd1:    begin tw_c =  16'sd15137; tw_s = -16'sd6270;  end
      4'd2:    begin tw_c =  16'sd11585; tw_s = -16'sd11585; end
      4'd3:    begin tw_c =  16'sd6270;  tw_s = -16'sd15137; end
      4'd4:    begin tw_c =  16'sd0;     tw_s = -16'sd16384; end
      4'd5:    begin tw_c = -16'sd6270;  tw_s = -16'sd15137; end
      4'd6:    begin tw_c = -16'sd11585; tw_s = -16'sd11585; end
      4'd7:    begin tw_c = -16'sd15137; tw_s = -16'sd6270;  end
      4'd8:    begin tw_c = -16'sd16384; tw_s =  16'sd0;     end
      default: begin tw_c = -16'sd15137; tw_s =  16'sd6270;  end
    endcase
    ma = lane_re[tq];
    mb = lane_im[tq];
    pr = 32'(ma) * 32'(tw_c) - 32'(mb) * 32'(tw_s) + 32'sd8192;
    pi = 32'(ma) * 32'(tw_s) + 32'(mb) * 32'(tw_c) + 32'sd8192;
    if (m == 4'd0) begin
      tw_re = ma;
      tw_im = mb;
    end else begin
      tw_re = sat(pr >>> 14);
      tw_im = sat(pi >>> 14);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      stage  <= 1'b0;
      g      <= '0;
      tq     <= '0;
      wcnt   <= '0;
      done_r <= 1'b0;
      for (int q = 0; q < 4; q++) begin
        lane_re[q] <= '0;
        lane_im[q] <= '0;
      end
    end else begin
      state  <= state_nxt;
      done_r <= 1'b0;
      case (state)
        S_IDLE:   if (start) begin
                    cnt   <= '0;
                    stage <= 1'b0;
                    g     <= '0;
                  end
        S_LOAD:   if (in_valid) cnt <= cnt + 4'd1;
        S_ISSUE:  begin
                    tq   <= '0;
                    wcnt <= WW'((BF_LAT > 0) ? BF_LAT - 1 : 0);
                  end
        S_WAIT:   wcnt <= wcnt - 1'b1;
        S_TWID:   begin
                    lane_re[tq] <= tw_re;
                    lane_im[tq] <= tw_im;
                    tq          <= tq + 2'd1;
                  end
        S_WRITE:  begin
                    g <= g + 2'd1;
                    if (g == 2'd3) stage <= ~stage;
                  end
        S_UNLOAD: if (out_ready) begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) done_r <= 1'b1;
                  end
        default:  ;
      endcase
      if (cap_en) begin
        for (int q = 0; q < 4; q++) begin
          lane_re[q] <= scale(bf_out[(7-2*q)*DW +: DW]);
          lane_im[q] <= scale(bf_out[(6-2*q)*DW +: DW]);
        end
      end
    end
  end

  // Sample buffer carries no reset; its contents are meaningless outside a frame.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) begin
      mem_re[cnt] <= in_re;
      mem_im[cnt] <= in_im;
    end else if (state == S_WRITE) begin
      for (int q = 0; q < 4; q++) begin
        mem_re[lane_addr(stage, g, q[1:0])] <= lane_re[q];
        mem_im[lane_addr(stage, g, q[1:0])] <= lane_im[q];
      end
    end
  end

  assign uaddr     = {cnt[1:0], cnt[3:2]};
  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_UNLOAD);
  assign out_re    = out_valid ? mem_re[uaddr] : '0;
  assign out_im    = out_valid ? mem_im[uaddr] : '0;
  assign out_idx   = out_valid ? cnt : '0;
  assign busy      = (state != S_IDLE);
  assign done      = done_r;

endmodule

// File: tb/tb_fft16_r4_sched.sv
// Directed bench for fft16_r4_sched: one instance with a combinational butterfly
// (BF_LAT=0) and one with a two-cycle pipelined butterfly (BF_LAT=2).
module tb_fft16_r4_sched;
  localparam int DW = 16;

  logic clk, rst_n, start, in_valid;
  logic [DW-1:0] in_re, in_im;
  logic in_ready0, in_ready2, out_valid0, out_valid2, out_ready0, out_ready2;
  logic [8*DW-1:0] bf_in0, bf_in2, bf_out0, bf_out2, pipe1, pipe2;
  logic [DW-1:0] out_re0, out_im0, out_re2, out_im2;
  logic [3:0] out_idx0, out_idx2;
  logic busy0, busy2, done0, done2;

  logic sel;
  logic ov;
  logic [DW-1:0] ore, oim;
  logic [3:0] oidx;

  int errors = 0;
  int checks = 0;
  int dcnt0 = 0;
  int dcnt2 = 0;
  logic signed [DW-1:0] xr [16];
  logic signed [DW-1:0] xi [16];
  logic signed [DW-1:0] yr [16];
  logic signed [DW-1:0] yi [16];

  fft16_r4_sched #(.DW(DW), .BF_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
    .in_re(in_re), .in_im(in_im), .bf_in(bf_in0), .bf_out(bf_out0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_re(out_re0), .out_im(out_im0),
    .out_idx(out_idx0), .busy(busy0), .done(done0)
  );

  fft16_r4_sched #(.DW(DW), .BF_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .in_re(in_re), .in_im(in_im), .bf_in(bf_in2), .bf_out(bf_out2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_re(out_re2), .out_im(out_im2),
    .out_idx(out_idx2), .busy(busy2), .done(done2)
  );

  // 4-point DFT with 16-bit wrap: out1 = A-jB-C+jD, out3 = A+jB-C-jD.
  function automatic logic [8*DW-1:0] bfly(input logic [8*DW-1:0] x);
    logic signed [DW-1:0] ar, ai, br, bi, cr, ci, dr, di;
    {ar, ai, br, bi, cr, ci, dr, di} = x;
    return {16'(ar + br + cr + dr), 16'(ai + bi + ci + di),
            16'(ar + bi - cr - di), 16'(ai - br - ci + dr),
            16'(ar - br + cr - dr), 16'(ai - bi + ci - di),
            16'(ar - bi - cr + di), 16'(ai + br - ci - dr)};
  endfunction

  assign bf_out0 = bfly(bf_in0);
  always @(posedge clk) begin
    pipe1 <= bfly(bf_in2);
    pipe2 <= pipe1;
  end
  assign bf_out2 = pipe2;

  assign ov   = sel ? out_valid2 : out_valid0;
  assign ore  = sel ? out_re2 : out_re0;
  assign oim  = sel ? out_im2 : out_im0;
  assign oidx = sel ? out_idx2 : out_idx0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done0) dcnt0++;
    if (done2) dcnt2++;
  end

  task automatic clear_frame;
    for (int i = 0; i < 16; i++) begin
      xr[i] = '0; xi[i] = '0; yr[i] = '0; yi[i] = '0;
    end
  endtask

  task automatic load_frame(output bit tmo);
    int guard;
    tmo = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      guard = 0;
      while (!(in_ready0 && in_ready2) && guard < 20) begin
        @(posedge clk); #1; guard++;
      end
      if (guard >= 20) tmo = 1'b1;
      in_valid = 1'b1; in_re = xr[i]; in_im = xi[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input bit s, input bit toggle, output int lat,
                           output int order_bad, output int hold_bad, output bit tmo);
    int k, guard;
    bit held, phase, rdy;
    logic [DW-1:0] hr, hi;
    logic [3:0] hx;
    sel = s; order_bad = 0; hold_bad = 0; lat = 0;
    load_frame(tmo);
    while (!ov && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    k = 0; guard = 0; phase = 1'b1; held = 1'b0; hr = '0; hi = '0; hx = '0;
    while (k < 16 && guard < 400) begin
      rdy = toggle ? phase : 1'b1;
      if (s) out_ready2 = rdy; else out_ready0 = rdy;
      if (held && (ov !== 1'b1 || ore !== hr || oim !== hi || oidx !== hx)) hold_bad++;
      held = 1'b0;
      if (ov && rdy) begin
        if (oidx !== k[3:0]) order_bad++;
        yr[k] = ore; yi[k] = oim;
        k++;
      end else if (ov) begin
        held = 1'b1; hr = ore; hi = oim; hx = oidx;
      end
      phase = ~phase;
      @(posedge clk); #1; guard++;
    end
    if (k < 16) tmo = 1'b1;
    out_ready0 = 1'b1; out_ready2 = 1'b1;
    guard = 0;
    while ((busy0 || busy2) && guard < 300) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 300) tmo = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    start = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; sel = 1'b0;
    out_ready0 = 1'b1; out_ready2 = 1'b1;
    rst_n = 1'b1; #2; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready0, out_valid0, busy0, done0, out_idx0, out_re0, out_im0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs0 got %h want 0",
               {in_ready0, out_valid0, busy0, done0, out_idx0, out_re0, out_im0});
    end
    checks++;
    if (bf_in0 !== '0) begin
      errors++; $display("FAIL reset_bf_in0 got %h want 0", bf_in0);
    end
    checks++;
    if ({in_ready2, out_valid2, busy2, done2, out_idx2, out_re2, out_im2, bf_in2} !== '0) begin
      errors++; $display("FAIL reset_outputs2 got nonzero want 0");
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0 || in_ready0 !== 1'b0) begin
      errors++; $display("FAIL idle_without_start busy=%b in_ready=%b want 0 0", busy0, in_ready0);
    end
  endtask

`ifndef FFT_SCALE_EN
  task automatic test_impulse;
    int lat, ob, hb, d0;
    bit tmo;
    clear_frame();
    xr[0] = 16'sd1000;
    d0 = dcnt0;
    run_frame(1'b0, 1'b0, lat, ob, hb, tmo);
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL impulse_timeout got 1 want 0"); end
    checks++;
    if (lat !== 32) begin errors++; $display("FAIL impulse_latency got %0d want 32", lat); end
    checks++;
    if (ob !== 0) begin errors++; $display("FAIL impulse_idx_order bad=%0d want 0", ob); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (yr[k] !== 16'sd1000 || yi[k] !== 16'sd0) begin
        errors++; $display("FAIL impulse X[%0d] got (%0d,%0d) want (1000,0)", k, yr[k], yi[k]);
      end
    end
    checks++;
    if (dcnt0 - d0 !== 1) begin
      errors++; $display("FAIL impulse_done_pulses got %0d want 1", dcnt0 - d0);
    end
  endtask

  task automatic test_dc;
    int lat, ob, hb;
    bit tmo;
    clear_frame();
    for (int i = 0; i < 16; i++) xr[i] = 16'sd100;
    run_frame(1'b0, 1'b0, lat, ob, hb, tmo);
    checks++;
    if (tmo !== 1'b0 || ob !== 0) begin
      errors++; $display("FAIL dc_stream tmo=%0d bad_idx=%0d want 0 0", tmo, ob);
    end
    checks++;
    if (yr[0] !== 16'sd1600 || yi[0] !== 16'sd0) begin
      errors++; $display("FAIL dc X[0] got (%0d,%0d) want (1600,0)", yr[0], yi[0]);
    end
    for (int k = 1; k < 16; k++) begin
      checks++;
      if (yr[k] !== 16'sd0 || yi[k] !== 16'sd0) begin
        errors++; $display("FAIL dc X[%0d] got (%0d,%0d) want (0,0)", k, yr[k], yi[k]);
      end
    end
  endtask

  task automatic test_shifted;
    int lat, ob, hb;
    bit tmo;
    clear_frame();
    xr[1] = 16'sd1000;
    run_frame(1'b0, 1'b0, lat, ob, hb, tmo);
    checks++;
    if (tmo !== 1'b0 || ob !== 0) begin
      errors++; $display("FAIL shift_stream tmo=%0d bad_idx=%0d want 0 0", tmo, ob);
    end
    checks++;
    if (yr[0] !== 16'sd1000 || yi[0] !== 16'sd0) begin
      errors++; $display("FAIL shift X[0] got (%0d,%0d) want (1000,0)", yr[0], yi[0]);
    end
    checks++;
    if (yr[1] !== 16'sd924 || yi[1] !== -16'sd383) begin
      errors++; $display("FAIL shift X[1] got (%0d,%0d) want (924,-383)", yr[1], yi[1]);
    end
    checks++;
    if (yr[2] !== 16'sd707 || yi[2] !== -16'sd707) begin
      errors++; $display("FAIL shift X[2] got (%0d,%0d) want (707,-707)", yr[2], yi[2]);
    end
    checks++;
    if (yr[4] !== 16'sd0 || yi[4] !== -16'sd1000) begin
      errors++; $display("FAIL shift X[4] got (%0d,%0d) want (0,-1000)", yr[4], yi[4]);
    end
    checks++;
    if (yr[8] !== -16'sd1000 || yi[8] !== 16'sd0) begin
      errors++; $display("FAIL shift X[8] got (%0d,%0d) want (-1000,0)", yr[8], yi[8]);
    end
  endtask

  task automatic test_backpressure;
    int lat, ob, hb, d2;
    bit tmo;
    clear_frame();
    for (int i = 0; i < 16; i++) xr[i] = 16'sd100;
    d2 = dcnt2;
    run_frame(1'b1, 1'b1, lat, ob, hb, tmo);
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL bp_timeout got 1 want 0"); end
    checks++;
    if (lat !== 48) begin errors++; $display("FAIL bp_latency got %0d want 48", lat); end
    checks++;
    if (ob !== 0) begin errors++; $display("FAIL bp_idx_order bad=%0d want 0", ob); end
    checks++;
    if (hb !== 0) begin errors++; $display("FAIL bp_hold_stable changes=%0d want 0", hb); end
    checks++;
    if (yr[0] !== 16'sd1600 || yi[0] !== 16'sd0) begin
      errors++; $display("FAIL bp X[0] got (%0d,%0d) want (1600,0)", yr[0], yi[0]);
    end
    for (int k = 1; k < 16; k++) begin
      checks++;
      if (yr[k] !== 16'sd0 || yi[k] !== 16'sd0) begin
        errors++; $display("FAIL bp X[%0d] got (%0d,%0d) want (0,0)", k, yr[k], yi[k]);
      end
    end
    checks++;
    if (dcnt2 - d2 !== 1) begin
      errors++; $display("FAIL bp_done_pulses got %0d want 1", dcnt2 - d2);
    end
  endtask

  task automatic test_reset_mid;
    int lat, ob, hb;
    bit tmo;
    logic [8*DW-1:0] exp_bf;
    clear_frame();
    xr[0] = 16'sd1000;
    sel = 1'b0;
    load_frame(tmo);
    exp_bf = '0;
    exp_bf[8*DW-1 -: DW] = 16'd1000;
    checks++;
    if (tmo !== 1'b0 || bf_in0 !== exp_bf) begin
      errors++; $display("FAIL issue_bf_in got %h want %h", bf_in0, exp_bf);
    end
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy0); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, in_ready0, out_valid0, done0, out_idx0, out_re0, out_im0, bf_in0} !== '0) begin
      errors++; $display("FAIL midreset_outputs0 busy=%b bf_in=%h want all 0", busy0, bf_in0);
    end
    checks++;
    if ({busy2, in_ready2, out_valid2, done2, out_idx2, out_re2, out_im2, bf_in2} !== '0) begin
      errors++; $display("FAIL midreset_outputs2 busy=%b want all 0", busy2);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL midreset_no_restart busy=%b%b want 00", busy0, busy2);
    end
    run_frame(1'b0, 1'b0, lat, ob, hb, tmo);
    checks++;
    if (tmo !== 1'b0 || ob !== 0) begin
      errors++; $display("FAIL postreset_stream tmo=%0d bad_idx=%0d want 0 0", tmo, ob);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (yr[k] !== 16'sd1000 || yi[k] !== 16'sd0) begin
        errors++; $display("FAIL postreset X[%0d] got (%0d,%0d) want (1000,0)", k, yr[k], yi[k]);
      end
    end
  endtask
`else
  task automatic test_scale;
    int lat, ob, hb;
    bit tmo;
    clear_frame();
    for (int i = 0; i < 16; i++) xr[i] = 16'sd1600;
    run_frame(1'b0, 1'b0, lat, ob, hb, tmo);
    checks++;
    if (tmo !== 1'b0 || ob !== 0 || lat !== 32) begin
      errors++; $display("FAIL scale_stream tmo=%0d bad_idx=%0d lat=%0d want 0 0 32", tmo, ob, lat);
    end
    checks++;
    if (yr[0] !== 16'sd1600 || yi[0] !== 16'sd0) begin
      errors++; $display("FAIL scale X[0] got (%0d,%0d) want (1600,0)", yr[0], yi[0]);
    end
    for (int k = 1; k < 16; k++) begin
      checks++;
      if (yr[k] !== 16'sd0 || yi[k] !== 16'sd0) begin
        errors++; $display("FAIL scale X[%0d] got (%0d,%0d) want (0,0)", k, yr[k], yi[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef FFT_SCALE_EN
    test_scale();
`else
    test_impulse();
    test_dc();
    test_shifted();
    test_backpressure();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
